// File: rtl/tlb_exp_commit_pkg.sv
// Shared exception codes, FSM state encodings and the CSR update bundle type
// for the commit-end TLB/address exception sequencer.
package tlb_exp_commit_pkg;

  localparam logic [5:0] ECODE_PIL  = 6'h01;
  localparam logic [5:0] ECODE_PIS  = 6'h02;
  localparam logic [5:0] ECODE_PIF  = 6'h03;
  localparam logic [5:0] ECODE_PME  = 6'h04;
  localparam logic [5:0] ECODE_PPI  = 6'h07;
  localparam logic [5:0] ECODE_ADE  = 6'h08;
  localparam logic [5:0] ECODE_TLBR = 6'h3F;

  // Full 7-bit codes as produced upstream: {Ecode, EsubCode bit}.
  // A TLBR carrying code bit 1 marks a refill raised by instruction fetch.
  localparam logic [6:0] EXP_PIL    = {ECODE_PIL,  1'b0};
  localparam logic [6:0] EXP_PIS    = {ECODE_PIS,  1'b0};
  localparam logic [6:0] EXP_PIF    = {ECODE_PIF,  1'b0};
  localparam logic [6:0] EXP_PME    = {ECODE_PME,  1'b0};
  localparam logic [6:0] EXP_PPI    = {ECODE_PPI,  1'b0};
  localparam logic [6:0] EXP_ADEF   = {ECODE_ADE,  1'b0};
  localparam logic [6:0] EXP_ADEM   = {ECODE_ADE,  1'b1};
  localparam logic [6:0] EXP_TLBR   = {ECODE_TLBR, 1'b0};
  localparam logic [6:0] EXP_TLBR_F = {ECODE_TLBR, 1'b1};

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FLUSH = 2'd1;
  localparam logic [1:0] ST_REDIR = 2'd2;

  typedef struct packed {
    logic [5:0]  ecode;
    logic [8:0]  esub;
    logic [31:0] era;
    logic        badv_we;
    logic [31:0] badv;
    logic        tlbr;
  } exp_bundle_t;

  function automatic logic badv_updates(input logic [6:0] code);
    return (code == EXP_ADEF) ||
           (code[6:1] == ECODE_TLBR) || (code[6:1] == ECODE_PIL) ||
           (code[6:1] == ECODE_PIS)  || (code[6:1] == ECODE_PIF) ||
           (code[6:1] == ECODE_PME)  || (code[6:1] == ECODE_PPI);
  endfunction

  function automatic logic badv_from_pc(input logic [6:0] code);
    return (code == EXP_ADEF) || (code[6:1] == ECODE_PIF) || (code == EXP_TLBR_F);
  endfunction

endpackage

// File: rtl/tlb_exp_commit_if.sv
// Commit-side bundle: per-slot exception inputs, CSR state, CSR update outputs
// and the front-end redirect handshake.
interface tlb_exp_commit_if;
  logic        cmt_valid0, cmt_valid1;
  logic [6:0]  exception0, exception1;
  logic        exp_flag0, exp_flag1;
  logic [31:0] pc0, pc1;
  logic [31:0] vaddr0, vaddr1;
  logic        ertn_i;
  logic [1:0]  crmd_plv_i;
  logic        crmd_ie_i;
  logic [1:0]  prmd_pplv_i;
  logic        prmd_pie_i;
  logic [31:0] era_i;
  logic [31:0] eentry_i;
  logic [31:0] tlbrentry_i;

  logic        csr_we_o;
  logic [5:0]  csr_ecode_o;
  logic [8:0]  csr_esub_o;
  logic [31:0] csr_era_o;
  logic        csr_badv_we_o;
  logic [31:0] csr_badv_o;
  logic        csr_tlbr_o;
  logic        csr_ertn_o;
  logic        flush_o;
  logic        redirect_valid_o;
  logic [31:0] redirect_pc_o;
  logic        redirect_ready_i;
  logic        busy_o;

  modport master (
    output cmt_valid0, cmt_valid1, exception0, exception1, exp_flag0, exp_flag1,
           pc0, pc1, vaddr0, vaddr1, ertn_i, crmd_plv_i, crmd_ie_i,
           prmd_pplv_i, prmd_pie_i, era_i, eentry_i, tlbrentry_i, redirect_ready_i,
    input  csr_we_o, csr_ecode_o, csr_esub_o, csr_era_o, csr_badv_we_o, csr_badv_o,
           csr_tlbr_o, csr_ertn_o, flush_o, redirect_valid_o, redirect_pc_o, busy_o
  );

  modport slave (
    input  cmt_valid0, cmt_valid1, exception0, exception1, exp_flag0, exp_flag1,
           pc0, pc1, vaddr0, vaddr1, ertn_i, crmd_plv_i, crmd_ie_i,
           prmd_pplv_i, prmd_pie_i, era_i, eentry_i, tlbrentry_i, redirect_ready_i,
    output csr_we_o, csr_ecode_o, csr_esub_o, csr_era_o, csr_badv_we_o, csr_badv_o,
           csr_tlbr_o, csr_ertn_o, flush_o, redirect_valid_o, redirect_pc_o, busy_o
  );
endinterface

// File: rtl/tlb_exp_commit_exp_slot_sel.sv
// Combinational oldest-slot selection and decode of the excepting slot into
// the CSR update bundle (Ecode/EsubCode, ERA, BADV source).
module exp_slot_sel
  import tlb_exp_commit_pkg::*;
(
  input  logic        cmt_valid0,
  input  logic        cmt_valid1,
  input  logic        exp_flag0,
  input  logic        exp_flag1,
  input  logic [6:0]  exception0,
  input  logic [6:0]  exception1,
  input  logic [31:0] pc0,
  input  logic [31:0] pc1,
  input  logic [31:0] vaddr0,
  input  logic [31:0] vaddr1,
  output logic        exp_valid,
  output exp_bundle_t bundle
);

  logic        take0;
  logic [6:0]  code;
  logic [31:0] pc;
  logic [31:0] vaddr;

  // Slot 0 is older, so it always wins when both slots except.
  always_comb begin
    take0     = cmt_valid0 & exp_flag0;
    exp_valid = take0 | (cmt_valid1 & exp_flag1);
    code      = take0 ? exception0 : exception1;
    pc        = take0 ? pc0 : pc1;
    vaddr     = take0 ? vaddr0 : vaddr1;

    bundle         = '0;
    bundle.ecode   = code[6:1];
    bundle.esub    = {8'd0, code[0]};
    bundle.era     = pc;
    bundle.badv_we = badv_updates(code);
    bundle.badv    = badv_from_pc(code) ? pc : vaddr;
    bundle.tlbr    = (code[6:1] == ECODE_TLBR);
  end

endmodule

// File: rtl/tlb_exp_commit.sv
// Commit-end exception/ERTN sequencer: CSR bundle strobe, flush, then redirect.
// Optional TLBR commit counter enabled by defining TLB_EXP_CNT_EN.
module tlb_exp_commit
  import tlb_exp_commit_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES = 2
)(
  input  logic         clk,
  input  logic         aresetn,
  tlb_exp_commit_if.slave cmt
`ifdef TLB_EXP_CNT_EN
  ,
  output logic [31:0]  tlbr_cnt_o
`endif
);

  logic [1:0]  state;
  logic [3:0]  flush_cnt;
  logic        csr_we;
  logic        ertn_q;
  logic [31:0] target_q;
  exp_bundle_t bundle_q;

  logic        exp_valid;
  exp_bundle_t sel_bundle;
  logic        ertn_take;
  logic        take_event;

  exp_slot_sel u_sel (
    .cmt_valid0 (cmt.cmt_valid0),
    .cmt_valid1 (cmt.cmt_valid1),
    .exp_flag0  (cmt.exp_flag0),
    .exp_flag1  (cmt.exp_flag1),
    .exception0 (cmt.exception0),
    .exception1 (cmt.exception1),
    .pc0        (cmt.pc0),
    .pc1        (cmt.pc1),
    .vaddr0     (cmt.vaddr0),
    .vaddr1     (cmt.vaddr1),
    .exp_valid  (exp_valid),
    .bundle     (sel_bundle)
  );

  // ERTN outranks a younger slot-1 exception but yields to one in slot 0.
  assign ertn_take  = cmt.cmt_valid0 & cmt.ertn_i & ~cmt.exp_flag0;
  assign take_event = (state == ST_IDLE) & (exp_valid | ertn_take);

  always_ff @(posedge clk) begin
    if (!aresetn) begin
      state     <= ST_IDLE;
      flush_cnt <= '0;
      csr_we    <= 1'b0;
      ertn_q    <= 1'b0;
      target_q  <= '0;
      bundle_q  <= '0;
    end else begin
      csr_we <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (take_event) begin
            csr_we    <= 1'b1;
            state     <= ST_FLUSH;
            flush_cnt <= 4'(FLUSH_CYCLES - 1);
            if (ertn_take) begin
              bundle_q <= '0;
              ertn_q   <= 1'b1;
              target_q <= cmt.era_i;
            end else begin
              bundle_q <= sel_bundle;
              ertn_q   <= 1'b0;
              target_q <= sel_bundle.tlbr ? cmt.tlbrentry_i : cmt.eentry_i;
            end
          end
        end
        ST_FLUSH: begin
          if (flush_cnt == 4'd0) state <= ST_REDIR;
          else                   flush_cnt <= flush_cnt - 4'd1;
        end
        ST_REDIR: begin
          if (cmt.redirect_ready_i) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign cmt.csr_we_o         = csr_we;
  assign cmt.csr_ecode_o      = bundle_q.ecode;
  assign cmt.csr_esub_o       = bundle_q.esub;
  assign cmt.csr_era_o        = bundle_q.era;
  assign cmt.csr_badv_we_o    = bundle_q.badv_we;
  assign cmt.csr_badv_o       = bundle_q.badv;
  assign cmt.csr_tlbr_o       = bundle_q.tlbr;
  assign cmt.csr_ertn_o       = ertn_q;
  assign cmt.flush_o          = (state == ST_FLUSH);
  assign cmt.redirect_valid_o = (state == ST_REDIR);
  assign cmt.redirect_pc_o    = target_q;
  assign cmt.busy_o           = (state != ST_IDLE);

`ifdef TLB_EXP_CNT_EN
  always_ff @(posedge clk) begin
    if (!aresetn)
      tlbr_cnt_o <= '0;
    else if (take_event && !ertn_take && sel_bundle.tlbr)
      tlbr_cnt_o <= tlbr_cnt_o + 32'd1;
  end
`endif

endmodule

// File: tb/tb_tlb_exp_commit.sv
// Directed self-checking bench for tlb_exp_commit (FLUSH_CYCLES=2); the TLBR
// counter check is compiled only when TLB_EXP_CNT_EN is defined.
module tb_tlb_exp_commit;

  localparam logic [31:0] EENTRY    = 32'h1C00_8000;
  localparam logic [31:0] TLBRENTRY = 32'h1C00_F000;

  logic clk = 1'b0;
  logic aresetn;
  int   checkCount = 0;
  int   failCount  = 0;

  tlb_exp_commit_if bus ();

`ifdef TLB_EXP_CNT_EN
  logic [31:0] tlbr_cnt;
`endif

  tlb_exp_commit #(.FLUSH_CYCLES(2)) dut (
    .clk     (clk),
    .aresetn (aresetn),
    .cmt     (bus)
`ifdef TLB_EXP_CNT_EN
    ,
    .tlbr_cnt_o (tlbr_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 ns after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic v0, input logic f0, input logic [6:0] e0,
                               input logic [31:0] p0, input logic [31:0] a0,
                               input logic v1, input logic f1, input logic [6:0] e1,
                               input logic [31:0] p1, input logic [31:0] a1,
                               input logic ertn);
    bus.cmt_valid0 = v0; bus.exp_flag0 = f0; bus.exception0 = e0;
    bus.pc0 = p0; bus.vaddr0 = a0;
    bus.cmt_valid1 = v1; bus.exp_flag1 = f1; bus.exception1 = e1;
    bus.pc1 = p1; bus.vaddr1 = a1;
    bus.ertn_i = ertn;
  endtask

  task automatic clearInputs();
    applyStimulus(0, 0, 7'h0, 32'h0, 32'h0, 0, 0, 7'h0, 32'h0, 32'h0, 0);
  endtask

  // Called one cycle after the event (csr_we cycle); walks flush and redirect with ready high.
  task automatic finishRedirect(input string tag, input logic [31:0] target);
    clearInputs();
    bus.redirect_ready_i = 1'b1;
    tick();
    checkOutput({tag, "_we_once"}, 32'(bus.csr_we_o), 32'd0);
    checkOutput({tag, "_flush2"},  32'(bus.flush_o), 32'd1);
    tick();
    checkOutput({tag, "_flush_end"}, 32'(bus.flush_o), 32'd0);
    checkOutput({tag, "_rvalid"},    32'(bus.redirect_valid_o), 32'd1);
    checkOutput({tag, "_rpc"},       bus.redirect_pc_o, target);
    tick();
    checkOutput({tag, "_idle"},  32'(bus.busy_o), 32'd0);
    checkOutput({tag, "_rdone"}, 32'(bus.redirect_valid_o), 32'd0);
  endtask

  initial begin
    aresetn = 1'b0;
    clearInputs();
    bus.crmd_plv_i = 2'd3; bus.crmd_ie_i = 1'b1;
    bus.prmd_pplv_i = 2'd0; bus.prmd_pie_i = 1'b0;
    bus.era_i = 32'h0; bus.eentry_i = EENTRY; bus.tlbrentry_i = TLBRENTRY;
    bus.redirect_ready_i = 1'b1;
    tick(); tick();
    checkOutput("rst_we",    32'(bus.csr_we_o), 32'd0);
    checkOutput("rst_flush", 32'(bus.flush_o), 32'd0);
    checkOutput("rst_rv",    32'(bus.redirect_valid_o), 32'd0);
    checkOutput("rst_busy",  32'(bus.busy_o), 32'd0);
    checkOutput("rst_rpc",   bus.redirect_pc_o, 32'h0);
    aresetn = 1'b1;
    tick();

    $display("[TB] test 1: slot0 TLBR");
    applyStimulus(1, 1, 7'h7E, 32'h1C00_0100, 32'h0040_0000, 1, 0, 7'h0, 32'h1C00_0104, 32'h0, 0);
    tick();
    checkOutput("t1_we",     32'(bus.csr_we_o), 32'd1);
    checkOutput("t1_ecode",  32'(bus.csr_ecode_o), 32'h3F);
    checkOutput("t1_esub",   32'(bus.csr_esub_o), 32'h0);
    checkOutput("t1_era",    bus.csr_era_o, 32'h1C00_0100);
    checkOutput("t1_badvwe", 32'(bus.csr_badv_we_o), 32'd1);
    checkOutput("t1_badv",   bus.csr_badv_o, 32'h0040_0000);
    checkOutput("t1_tlbr",   32'(bus.csr_tlbr_o), 32'd1);
    checkOutput("t1_ertn",   32'(bus.csr_ertn_o), 32'd0);
    checkOutput("t1_flush",  32'(bus.flush_o), 32'd1);
    checkOutput("t1_busy",   32'(bus.busy_o), 32'd1);
    finishRedirect("t1", TLBRENTRY);

    $display("[TB] test 2: slot1 PIS, later commits ignored while busy");
    applyStimulus(1, 0, 7'h0, 32'h1C00_0200, 32'h0, 1, 1, 7'h04, 32'h1C00_0204, 32'h8000_0010, 0);
    tick();
    checkOutput("t2_we",    32'(bus.csr_we_o), 32'd1);
    checkOutput("t2_ecode", 32'(bus.csr_ecode_o), 32'h02);
    checkOutput("t2_era",   bus.csr_era_o, 32'h1C00_0204);
    checkOutput("t2_badv",  bus.csr_badv_o, 32'h8000_0010);
    checkOutput("t2_tlbr",  32'(bus.csr_tlbr_o), 32'd0);
    applyStimulus(1, 1, 7'h10, 32'h1C00_0900, 32'h0, 0, 0, 7'h0, 32'h0, 32'h0, 0);
    tick();
    checkOutput("t2_busy_we",    32'(bus.csr_we_o), 32'd0);
    checkOutput("t2_busy_ecode", 32'(bus.csr_ecode_o), 32'h02);
    clearInputs();
    tick();
    checkOutput("t2_rpc", bus.redirect_pc_o, EENTRY);
    checkOutput("t2_era_kept", bus.csr_era_o, 32'h1C00_0204);
    tick();
    checkOutput("t2_idle", 32'(bus.busy_o), 32'd0);
    tick();
    checkOutput("t2_no_queue", 32'(bus.csr_we_o), 32'd0);

    $display("[TB] test 3: both slots excepting");
    applyStimulus(1, 1, 7'h02, 32'h1C00_0300, 32'h0000_1000, 1, 1, 7'h08, 32'h1C00_0304, 32'h0000_2000, 0);
    tick();
    checkOutput("t3_ecode", 32'(bus.csr_ecode_o), 32'h01);
    checkOutput("t3_era",   bus.csr_era_o, 32'h1C00_0300);
    checkOutput("t3_badv",  bus.csr_badv_o, 32'h0000_1000);
    finishRedirect("t3", EENTRY);

    $display("[TB] test 4: ERTN with slow redirect acceptance");
    bus.era_i = 32'h1C00_0200;
    bus.redirect_ready_i = 1'b0;
    applyStimulus(1, 0, 7'h0, 32'h1C00_0400, 32'h0, 1, 1, 7'h06, 32'h1C00_0404, 32'h0, 1);
    tick();
    checkOutput("t4_we",     32'(bus.csr_we_o), 32'd1);
    checkOutput("t4_ertn",   32'(bus.csr_ertn_o), 32'd1);
    checkOutput("t4_badvwe", 32'(bus.csr_badv_we_o), 32'd0);
    checkOutput("t4_tlbr",   32'(bus.csr_tlbr_o), 32'd0);
    clearInputs();
    tick(); tick();
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("t4_rv_hold%0d", i), 32'(bus.redirect_valid_o), 32'd1);
      checkOutput($sformatf("t4_rpc_hold%0d", i), bus.redirect_pc_o, 32'h1C00_0200);
      tick();
    end
    checkOutput("t4_rv_still", 32'(bus.redirect_valid_o), 32'd1);
    bus.redirect_ready_i = 1'b1;
    tick();
    checkOutput("t4_idle", 32'(bus.busy_o), 32'd0);
    checkOutput("t4_rdone", 32'(bus.redirect_valid_o), 32'd0);

    $display("[TB] test 5: reset during redirect");
    bus.redirect_ready_i = 1'b0;
    applyStimulus(1, 1, 7'h10, 32'h1C00_0400, 32'hDEAD_0000, 0, 0, 7'h0, 32'h0, 32'h0, 0);
    tick();
    checkOutput("t5_adef_badv",  bus.csr_badv_o, 32'h1C00_0400);
    checkOutput("t5_adef_ecode", 32'(bus.csr_ecode_o), 32'h08);
    clearInputs();
    tick(); tick();
    checkOutput("t5_in_redir", 32'(bus.redirect_valid_o), 32'd1);
    aresetn = 1'b0;
    tick();
    checkOutput("t5_rst_rv",    32'(bus.redirect_valid_o), 32'd0);
    checkOutput("t5_rst_busy",  32'(bus.busy_o), 32'd0);
    checkOutput("t5_rst_rpc",   bus.redirect_pc_o, 32'h0);
    checkOutput("t5_rst_badv",  bus.csr_badv_o, 32'h0);
    checkOutput("t5_rst_ecode", 32'(bus.csr_ecode_o), 32'h0);
    checkOutput("t5_rst_flush", 32'(bus.flush_o), 32'd0);
    aresetn = 1'b1;
    applyStimulus(1, 1, 7'h2B, 32'h1C00_0500, 32'h1234_5678, 0, 0, 7'h0, 32'h0, 32'h0, 0);
    tick();
    checkOutput("t5_we",     32'(bus.csr_we_o), 32'd1);
    checkOutput("t5_ecode",  32'(bus.csr_ecode_o), 32'h15);
    checkOutput("t5_esub",   32'(bus.csr_esub_o), 32'h1);
    checkOutput("t5_badvwe", 32'(bus.csr_badv_we_o), 32'd0);
    finishRedirect("t5", EENTRY);

`ifdef TLB_EXP_CNT_EN
    $display("[TB] test 6: TLBR counter");
    for (int i = 0; i < 7; i++) begin
      if (i < 5)
        applyStimulus(1, 1, 7'h7E, 32'h1C00_1000, 32'h0, 0, 0, 7'h0, 32'h0, 32'h0, 0);
      else
        applyStimulus(1, 1, 7'h06, 32'h1C00_2000, 32'h0, 0, 0, 7'h0, 32'h0, 32'h0, 0);
      tick();
      finishRedirect($sformatf("t6_%0d", i), (i < 5) ? TLBRENTRY : EENTRY);
    end
    checkOutput("t6_cnt", tlbr_cnt, 32'd5);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
